// File: rtl/cla_pkg.sv
// Shared constants and types for the 4-bit carry-lookahead adder slice.
package cla_pkg;

    localparam int CLA_W = 4;

    typedef logic [CLA_W-1:0] nib_t;

endpackage : cla_pkg

// File: rtl/cla_lookahead.sv
// Flat two-level carry-lookahead unit for one 4-bit group.
// Every carry is a sum of products of G/P/Cin, so no term waits on another carry.
// The same block is reused at the 16-bit level, driven by group G/P.
module cla_lookahead
    import cla_pkg::*;
(
    input  nib_t G,
    input  nib_t P,
    input  logic Cin,
    output nib_t C,
    output logic PG,
    output logic GG,
    output logic Cout
);

    logic [CLA_W-1:0] c_s;
    logic             pg_s;
    logic             gg_s;

    // Lookahead carries and group terms as two-level sum of products.
    always_comb begin
        c_s    = 4'b0000;
        c_s[0] = Cin;
        c_s[1] = G[0] | (P[0] & Cin);
        c_s[2] = G[1] | (P[1] & G[0]) | (P[1] & P[0] & Cin);
        c_s[3] = G[2] | (P[2] & G[1]) | (P[2] & P[1] & G[0])
               | (P[2] & P[1] & P[0] & Cin);
        pg_s   = P[3] & P[2] & P[1] & P[0];
        gg_s   = G[3] | (P[3] & G[2]) | (P[3] & P[2] & G[1])
               | (P[3] & P[2] & P[1] & G[0]);
    end

    assign C    = c_s;
    assign PG   = pg_s;
    assign GG   = gg_s;
    // Carry out comes from the group terms, not from c_s[3], keeping it flat.
    assign Cout = gg_s | (pg_s & Cin);

endmodule : cla_lookahead

// File: rtl/cla_four_bit.sv
// Registered 4-bit carry-lookahead adder: {Cout, S} = A + B + Cin with one
// cycle of latency, plus bit G/P, internal carries and group PG/GG outputs
// for cascading into a higher lookahead level.
module cla_four_bit
    import cla_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] G,
    output logic [3:0] P,
    output logic [3:0] C,
    output logic [3:0] S,
    output logic       Cout,
    output logic       PG,
    output logic       GG
);

    nib_t g_s;
    nib_t p_s;
    nib_t c_s;
    nib_t s_s;
    logic pg_s;
    logic gg_s;
    logic cout_s;

    // Bit generate/propagate; XOR propagate lets the sum reuse it directly.
    always_comb begin
        g_s = A & B;
        p_s = A ^ B;
    end

    cla_lookahead u_lookahead (
        .G    (g_s),
        .P    (p_s),
        .Cin  (Cin),
        .C    (c_s),
        .PG   (pg_s),
        .GG   (gg_s),
        .Cout (cout_s)
    );

    // Sum is one XOR after the lookahead carries.
    always_comb begin
        s_s = p_s ^ c_s;
    end

    // Output register bank; reset clears everything without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            G    <= 4'b0000;
            P    <= 4'b0000;
            C    <= 4'b0000;
            S    <= 4'b0000;
            Cout <= 1'b0;
            PG   <= 1'b0;
            GG   <= 1'b0;
        end else begin
            G    <= g_s;
            P    <= p_s;
            C    <= c_s;
            S    <= s_s;
            Cout <= cout_s;
            PG   <= pg_s;
            GG   <= gg_s;
        end
    end

endmodule : cla_four_bit

// File: tb/tb_cla_four_bit.sv
// Self-checking bench for cla_four_bit: directed cases, reset behaviour,
// randomized vectors against an arithmetic reference model, and an
// exhaustive {Cout,S} sweep.
module tb_cla_four_bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] G;
    logic [3:0] P;
    logic [3:0] C;
    logic [3:0] S;
    logic       Cout;
    logic       PG;
    logic       GG;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    cla_four_bit dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .G    (G),
        .P    (P),
        .C    (C),
        .S    (S),
        .Cout (Cout),
        .PG   (PG),
        .GG   (GG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of all outputs: {G,P,C,S,Cout,PG,GG}.
    function automatic logic [18:0] outs();
        return {G, P, C, S, Cout, PG, GG};
    endfunction

    // Reference: carries come from partial sums of the low bits, group
    // generate from whether A+B alone overflows, group propagate from A^B=F.
    function automatic logic [18:0] model(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic [3:0] mask;
        logic [4:0] part;
        logic [4:0] sum;
        logic [4:0] ab;
        g = a & b;
        p = a ^ b;
        for (int i = 0; i < 4; i++) begin
            mask = 4'b0000;
            for (int j = 0; j < i; j++) mask[j] = 1'b1;
            part = {1'b0, a & mask} + {1'b0, b & mask} + {4'b0000, cin};
            c[i] = part[i];
        end
        sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        ab  = {1'b0, a} + {1'b0, b};
        return {g, p, c, sum[3:0], sum[4], (p == 4'b1111), ab[4]};
    endfunction

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample #1 after the next rising edge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        @(posedge clk);
        #1;
    endtask

    logic [18:0] held;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        rc;
    logic [4:0]  want5;

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        rst = 1'b0;
        A   = 4'hF;
        B   = 4'hF;
        Cin = 1'b1;

        // Reset asserted between edges must clear outputs at once.
        #2;
        rst = 1'b1;
        #1;
        check("reset_immediate", outs(), 19'h0);
        @(posedge clk); #1;
        check("reset_hold_1", outs(), 19'h0);
        @(posedge clk); #1;
        check("reset_hold_2", outs(), 19'h0);
        @(negedge clk);
        rst = 1'b0;

        // First edge after release captures the inputs present then (F+F+1).
        @(posedge clk); #1;
        check("post_reset_first", outs(), {4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1});

        apply(4'b0000, 4'b0000, 1'b0);
        check("zero", outs(), 19'h0);
        apply(4'b0101, 4'b0011, 1'b1);
        check("d_5_3_1", outs(), {4'b0001, 4'b0110, 4'b1111, 4'b1001, 1'b0, 1'b0, 1'b0});
        apply(4'b1111, 4'b0001, 1'b0);
        check("d_f_1_0", outs(), {4'b0001, 4'b1110, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b1});
        apply(4'b1001, 4'b0110, 1'b1);
        check("d_pg_cin", outs(), {4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0});
        apply(4'b1010, 4'b1101, 1'b0);
        check("d_a_d_0", outs(), {4'b1000, 4'b0111, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b1});

        // Input changes between edges must not reach the outputs.
        held = outs();
        A   = 4'b0110;
        B   = 4'b0111;
        Cin = 1'b1;
        #2;
        check("between_edges", outs(), held);
        @(posedge clk); #1;
        check("after_change", outs(), model(4'b0110, 4'b0111, 1'b1));

        // Mid-stream reset discards the in-flight result immediately.
        @(negedge clk);
        A   = 4'b1011;
        B   = 4'b0101;
        Cin = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_immediate", outs(), 19'h0);
        @(posedge clk); #1;
        check("mid_reset_hold", outs(), 19'h0);
        @(negedge clk);
        rst = 1'b0;
        apply(4'b1011, 4'b0101, 1'b0);
        check("mid_reset_recover", outs(), model(4'b1011, 4'b0101, 1'b0));

        // Randomized vectors against the reference model.
        for (int k = 0; k < 200; k++) begin
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            rc = 1'($urandom_range(1, 0));
            apply(ra, rb, rc);
            check("random", outs(), model(ra, rb, rc));
        end

        // Exhaustive sweep of the arithmetic result.
        for (int v = 0; v < 512; v++) begin
            ra = 4'(v >> 5);
            rb = 4'(v >> 1);
            rc = 1'(v);
            want5 = 5'(32'(ra) + 32'(rb) + 32'(rc));
            apply(ra, rb, rc);
            check("sweep_sum", {14'h0, Cout, S}, {14'h0, want5});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_cla_four_bit
